// File: rtl/arith_select_buf_if.sv
// Handshake bundle for arith_select_buf: condition, true/false operand inputs and
// the buffered result output. The slave modport is the select stage itself.
interface arith_select_buf_if #(
    parameter int WIDTH = 32
);
    // valid/ready: a token moves on any rising edge where valid and ready are
    // both high; a producer holds valid and data stable until that happens.
    logic             cond_valid;
    logic             cond_ready;
    logic             cond_data;
    logic             t_valid;
    logic             t_ready;
    logic [WIDTH-1:0] t_data;
    logic             f_valid;
    logic             f_ready;
    logic [WIDTH-1:0] f_data;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result_data;

    modport slave (
        input  cond_valid, cond_data, t_valid, t_data, f_valid, f_data, result_ready,
        output cond_ready, t_ready, f_ready, result_valid, result_data
    );

    modport master (
        output cond_valid, cond_data, t_valid, t_data, f_valid, f_data, result_ready,
        input  cond_ready, t_ready, f_ready, result_valid, result_data
    );
endinterface

// File: rtl/arith_select_buf.sv
// arith.select join stage: consumes cond/t/f together, forwards the selected operand
// into a 2-entry elastic buffer. Input readies never depend on result_ready.
module arith_select_buf #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    arith_select_buf_if.slave     bus,
    output logic [1:0]            o_dbg_count
);
    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic             w_space;
    logic             w_all_v;
    logic             w_push;
    logic             w_pop;
    logic             w_result_valid;
    logic [WIDTH-1:0] w_sel_data;
    logic [1:0]       w_count_nxt;

    // Readies are forced low during reset so nothing is consumed while flushing.
    always_comb begin
        w_space = (r_count != 2'd2);
        w_all_v = bus.cond_valid & bus.t_valid & bus.f_valid;
        w_push  = w_all_v & w_space & ~rst;
        w_result_valid = (r_count != 2'd0) & ~rst;
        w_pop   = w_result_valid & bus.result_ready;
        w_sel_data = bus.cond_data ? bus.t_data : bus.f_data;
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_sel_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        bus.cond_ready   = w_space & ~rst & bus.t_valid & bus.f_valid;
        bus.t_ready      = w_space & ~rst & bus.cond_valid & bus.f_valid;
        bus.f_ready      = w_space & ~rst & bus.cond_valid & bus.t_valid;
        bus.result_valid = w_result_valid;
        bus.result_data  = rst ? '0 : r_mem[r_rd_ptr];
        o_dbg_count      = r_count;
    end
endmodule

// File: tb/tb_arith_select_buf.sv
// Directed and random bench for arith_select_buf against a queue-based model.
module tb_arith_select_buf;
    localparam int W = 32;

    logic clk;
    logic rst;
    logic [1:0] dbg_count;
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    arith_select_buf_if #(.WIDTH(W)) bus ();

    arith_select_buf #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_count (dbg_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (dbg_count <= 2'd2) else begin
                errors++;
                $error("FAIL count_bound observed=%0d expected<=2", dbg_count);
            end
        end
    end

    task automatic drive(input logic cv, input logic cd, input logic tv, input logic [W-1:0] td,
                         input logic fv, input logic [W-1:0] fd, input logic rr);
        bus.cond_valid   = cv;
        bus.cond_data    = cd;
        bus.t_valid      = tv;
        bus.t_data       = td;
        bus.f_valid      = fv;
        bus.f_data       = fd;
        bus.result_ready = rr;
    endtask

    // One cycle: drive, check outputs against the model, clock, update the model.
    task automatic step(input string tag, input logic cv, input logic cd, input logic tv,
                        input logic [W-1:0] td, input logic fv, input logic [W-1:0] fd,
                        input logic rr);
        bit sp, acc, pop;
        drive(cv, cd, tv, td, fv, fd, rr);
        #1;
        sp  = (exp_q.size() < 2);
        acc = sp && cv && tv && fv;
        pop = (exp_q.size() != 0) && rr;
        chk({tag, ".cond_ready"}, W'(bus.cond_ready), W'(sp && tv && fv));
        chk({tag, ".t_ready"}, W'(bus.t_ready), W'(sp && cv && fv));
        chk({tag, ".f_ready"}, W'(bus.f_ready), W'(sp && cv && tv));
        chk({tag, ".result_valid"}, W'(bus.result_valid), W'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk({tag, ".result_data"}, bus.result_data, exp_q[0]);
        chk({tag, ".count"}, W'(dbg_count), W'(exp_q.size()));
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(cd ? td : fd);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h55, 1'b1, 32'h66, 1'b1);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("rst.cond_ready", W'(bus.cond_ready), '0);
            chk("rst.t_ready", W'(bus.t_ready), '0);
            chk("rst.f_ready", W'(bus.f_ready), '0);
            chk("rst.result_valid", W'(bus.result_valid), '0);
            chk("rst.result_data", bus.result_data, '0);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);

        do_reset(2);
        step("post_rst", 0, 0, 0, 0, 0, 0, 1);

        // Select, back-to-back at full rate
        step("sel1", 1, 1, 1, 32'h11, 1, 32'h22, 1);
        step("sel0", 1, 0, 1, 32'h33, 1, 32'h44, 1);
        step("sel_drain", 0, 0, 0, 0, 0, 0, 1);
        step("sel_empty", 0, 0, 0, 0, 0, 0, 1);

        // Join stall with f missing
        for (int i = 0; i < 5; i++) step("stall", 1, 1, 1, 32'h77, 0, 32'h88, 1);
        step("join", 1, 1, 1, 32'h77, 1, 32'h88, 1);
        step("join_out", 0, 0, 0, 0, 0, 0, 1);

        // Backpressure then full + pop
        step("bp_a", 1, 1, 1, 32'hA, 1, 0, 0);
        step("bp_b", 1, 1, 1, 32'hB, 1, 0, 0);
        step("bp_c_full", 1, 1, 1, 32'hC, 1, 0, 0);
        step("bp_c_full", 1, 1, 1, 32'hC, 1, 0, 0);
        step("full_pop", 1, 1, 1, 32'hC, 1, 0, 1);
        step("c_accept", 1, 1, 1, 32'hC, 1, 0, 1);
        for (int i = 0; i < 3; i++) step("bp_drain", 0, 0, 0, 0, 0, 0, 1);

        // Reset with a full buffer drops the tokens
        step("mr_a", 1, 0, 1, 0, 1, 32'hD1, 0);
        step("mr_b", 1, 0, 1, 0, 1, 32'hD2, 0);
        do_reset(1);
        for (int i = 0; i < 3; i++) step("mr_after", 0, 0, 0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 3) != 0), W'($urandom()),
                 logic'($urandom_range(0, 3) != 0), W'($urandom()),
                 logic'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) step("rnd_drain", 0, 0, 0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
